// File: rtl/even_parity_rx.sv
// Serial even-parity frame receiver: reassembles {data, parity} frames MSB first,
// flags parity errors, buffers one frame on a valid/ready port and keeps error stats.
module even_parity_rx #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              frame_start,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              overflow,
    input  logic              err_clr
);

    localparam int                BCNT_W   = $clog2(DATA_W + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e            state_q, state_d;
    logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_perr_q, out_perr_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              overflow_q, overflow_d;

    logic frame_done;
    logic frame_perr;
    logic buf_free;

    // Frame assembly. The shift register only needs the payload: the parity
    // bit is consumed straight from bit_in on the completing edge.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        frame_perr = ^{shift_q, bit_in};

        if (bit_valid) begin
            shift_d = {shift_q[DATA_W-2:0], bit_in};
        end

        case (state_q)
            IDLE: begin
                if (bit_valid) begin
                    state_d   = SHIFT;
                    bit_cnt_d = BCNT_W'(1);
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    // The parity bit always completes; frame_start only restarts earlier bits.
                    if (bit_cnt_q == LAST_BIT) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                        bit_cnt_d  = '0;
                    end else if (frame_start) begin
                        bit_cnt_d = BCNT_W'(1);
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                    end
                end else if (frame_start) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // One-entry output buffer and statistics.
    always_comb begin
        buf_free    = !out_valid_q || out_ready;
        out_data_d  = out_data_q;
        out_perr_d  = out_perr_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        err_cnt_d   = err_cnt_q;

        if (frame_done && buf_free) begin
            out_data_d  = shift_q;
            out_perr_d  = frame_perr;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A same-edge event beats err_clr for both statistics.
        if (frame_done && !buf_free) begin
            overflow_d = 1'b1;
        end else if (err_clr) begin
            overflow_d = 1'b0;
        end

        if (frame_done && frame_perr) begin
            if (err_clr) begin
                err_cnt_d = CNT_W'(1);
            end else if (err_cnt_q != CNT_MAX) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end else if (err_clr) begin
            err_cnt_d = '0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_perr_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_cnt_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_perr_q  <= out_perr_d;
            out_valid_q <= out_valid_d;
            err_cnt_q   <= err_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_perr  = out_perr_q;
    assign out_valid = out_valid_q;
    assign err_cnt   = err_cnt_q;
    assign overflow  = overflow_q;

endmodule
